// File: rtl/aes_cmd_initiator_if.sv
// rtl/aes_cmd_initiator_if.sv - host descriptor handshake and AES MMIO command bus
`timescale 1ns/1ps
interface aes_cmd_initiator_if;
  logic         req_valid;
  logic         req_ready;
  logic [15:0]  req_addr;
  logic [15:0]  req_len;
  logic [127:0] req_ctr;
  logic [127:0] req_key;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   cmd;
  logic [15:0]  cmdaddr;
  logic [7:0]   cmddata;
  logic [7:0]   outdata;

  modport master (
    input  req_valid, req_addr, req_len, req_ctr, req_key, outdata,
    output req_ready, busy, done, err, cmd, cmdaddr, cmddata
  );

  modport slave (
    output req_valid, req_addr, req_len, req_ctr, req_key, outdata,
    input  req_ready, busy, done, err, cmd, cmdaddr, cmddata
  );
endinterface

// File: rtl/aes_cmd_initiator.sv
// rtl/aes_cmd_initiator.sv - programs one AES job over the MMIO command port and polls for idle
`timescale 1ns/1ps
module aes_cmd_initiator #(
  parameter logic [15:0] REG_BASE    = 16'hff00,
  parameter logic [15:0] POLL_MAX    = 16'd1024,
  parameter logic [7:0]  STATUS_IDLE = 8'h00,
  parameter logic [7:0]  START_VAL   = 8'h01
) (
  input  logic                       clk,
  input  logic                       rst,
  aes_cmd_initiator_if.master        bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_LEN, S_WR_CTR, S_WR_KEY, S_WR_START,
    S_POLL_RD, S_POLL_WAIT, S_DONE
  } state_t;

  state_t        r_state;
  logic [5:0]    r_idx;
  logic [15:0]   r_polls;
  logic [15:0]   r_addr;
  logic [15:0]   r_len;
  logic [127:0]  r_ctr;
  logic [127:0]  r_key;
  logic [1:0]    r_cmd;
  logic [15:0]   r_cmdaddr;
  logic [7:0]    r_cmddata;
  logic          r_done;
  logic          r_err;
  logic          r_busy;
  logic          r_ready;

  // Write k of the 37-byte program sequence: {register address, data byte}.
  function automatic logic [23:0] wr_cmd(input logic [5:0] k, input logic [15:0] a,
                                         input logic [15:0] l, input logic [127:0] c,
                                         input logic [127:0] y);
    logic [5:0]  o;
    logic [23:0] f;
    o = 6'd0;
    f = {REG_BASE, START_VAL};
    if (k < 6'd2) begin
      o = k;
      f = {REG_BASE + 16'h0002 + {10'd0, o}, a[{o[0], 3'b000} +: 8]};
    end else if (k < 6'd4) begin
      o = k - 6'd2;
      f = {REG_BASE + 16'h0004 + {10'd0, o}, l[{o[0], 3'b000} +: 8]};
    end else if (k < 6'd20) begin
      o = k - 6'd4;
      f = {REG_BASE + 16'h0010 + {10'd0, o}, c[{o[3:0], 3'b000} +: 8]};
    end else if (k < 6'd36) begin
      o = k - 6'd20;
      f = {REG_BASE + 16'h0020 + {10'd0, o}, y[{o[3:0], 3'b000} +: 8]};
    end
    return f;
  endfunction

  function automatic state_t st_of(input logic [5:0] k);
    if (k < 6'd2)       return S_WR_ADDR;
    else if (k < 6'd4)  return S_WR_LEN;
    else if (k < 6'd20) return S_WR_CTR;
    else if (k < 6'd36) return S_WR_KEY;
    else                return S_WR_START;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 6'd0;
      r_polls   <= 16'd0;
      r_addr    <= 16'd0;
      r_len     <= 16'd0;
      r_ctr     <= 128'd0;
      r_key     <= 128'd0;
      r_cmd     <= 2'b00;
      r_cmdaddr <= 16'd0;
      r_cmddata <= 8'd0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr  <= bus.req_addr;
            r_len   <= bus.req_len;
            r_ctr   <= bus.req_ctr;
            r_key   <= bus.req_key;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_polls <= 16'd0;
            if (bus.req_len == 16'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b0;
            end else begin
              // Outputs are registered, so the first write is launched on the accept edge.
              r_state <= S_WR_ADDR;
              r_cmd   <= 2'b10;
              {r_cmdaddr, r_cmddata} <= wr_cmd(6'd0, bus.req_addr, bus.req_len,
                                               bus.req_ctr, bus.req_key);
              r_idx   <= 6'd1;
            end
          end
        end
        S_WR_ADDR, S_WR_LEN, S_WR_CTR, S_WR_KEY, S_WR_START: begin
          if (r_idx == 6'd37) begin
            r_state   <= S_POLL_RD;
            r_cmd     <= 2'b01;
            r_cmdaddr <= REG_BASE + 16'h0001;
            r_cmddata <= 8'd0;
          end else begin
            r_state <= st_of(r_idx);
            {r_cmdaddr, r_cmddata} <= wr_cmd(r_idx, r_addr, r_len, r_ctr, r_key);
            r_idx   <= r_idx + 6'd1;
          end
        end
        S_POLL_RD: begin
          r_state <= S_POLL_WAIT;
          r_cmd   <= 2'b00;
          if (r_polls != POLL_MAX) r_polls <= r_polls + 16'd1;
        end
        S_POLL_WAIT: begin
          if (bus.outdata == STATUS_IDLE) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
          end else if (r_polls == POLL_MAX) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_state <= S_POLL_RD;
            r_cmd   <= 2'b01;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_idx   <= 6'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.cmd       = r_cmd;
  assign bus.cmdaddr   = r_cmdaddr;
  assign bus.cmddata   = r_cmddata;

endmodule

// File: tb/tb_aes_cmd_initiator.sv
// tb/tb_aes_cmd_initiator.sv - directed vector bench for aes_cmd_initiator with a small AES status model
`timescale 1ns/1ps
module tb_aes_cmd_initiator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_cmd_initiator_if bus ();

  aes_cmd_initiator #(.POLL_MAX(16'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          chk_addr;
    bit          chk_data;
  } vec_t;

  vec_t tbl [1:39];

  int n_vec = 0;
  int n_bad = 0;

  // AES status model: the first resp_busy reads of a job return 1, later reads return idle.
  int rd_count  = 0;
  int rd_base   = 0;
  int resp_busy = 0;
  always @(negedge clk) begin
    if (bus.cmd == 2'b01) begin
      bus.outdata = ((rd_count - rd_base) < resp_busy) ? 8'h01 : 8'h00;
      rd_count++;
    end
  end

  logic [1:0]  lg_cmd  [0:127];
  logic [15:0] lg_addr [0:127];
  logic [7:0]  lg_data [0:127];
  int   done_cyc;
  logic done_err;
  int   n_reads;
  int   n_cmd;
  int   n_bad11;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Presents one descriptor at a negedge (cycle 0) and logs outputs per cycle until done.
  task automatic run_job(input logic [15:0] a, input logic [15:0] l, input logic [127:0] c,
                         input logic [127:0] k, input int nbusy, input bit hold);
    @(negedge clk);
    bus.req_addr  = a;
    bus.req_len   = l;
    bus.req_ctr   = c;
    bus.req_key   = k;
    bus.req_valid = 1'b1;
    resp_busy     = nbusy;
    rd_base       = rd_count;
    chk("ready_at_request", bus.req_ready, 1);
    done_cyc = -1;
    done_err = 1'b0;
    n_reads  = 0;
    n_cmd    = 0;
    n_bad11  = 0;
    for (int r = 1; r < 128; r++) begin
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
      if (r == 1) begin
        bus.req_addr = 16'hc35a;
        bus.req_len  = 16'h0001;
        bus.req_ctr  = '1;
        bus.req_key  = '1;
      end
      lg_cmd[r]  = bus.cmd;
      lg_addr[r] = bus.cmdaddr;
      lg_data[r] = bus.cmddata;
      if (bus.cmd == 2'b01) n_reads++;
      if (bus.cmd != 2'b00) n_cmd++;
      if (bus.cmd == 2'b11) n_bad11++;
      if (bus.done) begin
        done_cyc = r;
        done_err = bus.err;
        break;
      end
    end
    chk("job_done_within_budget", (done_cyc >= 0), 1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_ctr   = '0;
    bus.req_key   = '0;
    bus.outdata   = 8'h00;

    tbl[1] = '{2'b10, 16'hff02, 8'h34, 1, 1};
    tbl[2] = '{2'b10, 16'hff03, 8'h12, 1, 1};
    tbl[3] = '{2'b10, 16'hff04, 8'h10, 1, 1};
    tbl[4] = '{2'b10, 16'hff05, 8'h00, 1, 1};
    for (int i = 0; i < 16; i++) begin
      tbl[5 + i]  = '{2'b10, 16'hff10 + 16'(i), 8'(i), 1, 1};
      tbl[21 + i] = '{2'b10, 16'hff20 + 16'(i), 8'h20 + 8'(i), 1, 1};
    end
    tbl[37] = '{2'b10, 16'hff00, 8'h01, 1, 1};
    tbl[38] = '{2'b01, 16'hff01, 8'h00, 1, 0};
    tbl[39] = '{2'b00, 16'h0000, 8'h00, 0, 0};

    #12;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done_err", {bus.done, bus.err}, 0);
    chk("rst_cmd", bus.cmd, 0);
    chk("rst_cmdaddr_data", {bus.cmdaddr, bus.cmddata}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reference job: full write program, idle on first poll.
    run_job(16'h1234, 16'h0010, 128'h0f0e0d0c0b0a09080706050403020100,
            128'h2f2e2d2c2b2a29282726252423222120, 0, 0);
    for (int r = 1; r <= 39; r++) begin
      chk($sformatf("main_c%0d_cmd", r), lg_cmd[r], tbl[r].cmd);
      if (tbl[r].chk_addr) chk($sformatf("main_c%0d_addr", r), lg_addr[r], tbl[r].addr);
      if (tbl[r].chk_data) chk($sformatf("main_c%0d_data", r), lg_data[r], tbl[r].data);
    end
    chk("main_done_cycle", done_cyc, 40);
    chk("main_err", done_err, 0);
    chk("main_cmd_cycles", n_cmd, 38);
    chk("main_no_cmd11", n_bad11, 0);

    // Three busy polls then idle: the 4th read lands exactly on POLL_MAX and is still a success.
    run_job(16'h0100, 16'h0040, '0, '0, 3, 0);
    chk("poll3_reads", n_reads, 4);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("poll3_rd%0d", p), {lg_cmd[38 + 2 * p], lg_addr[38 + 2 * p]}, {2'b01, 16'hff01});
      chk($sformatf("poll3_gap%0d", p), lg_cmd[39 + 2 * p], 2'b00);
    end
    chk("poll3_done_cycle", done_cyc, 46);
    chk("poll3_err", done_err, 0);

    // Status stuck busy: timeout after exactly POLL_MAX reads.
    run_job(16'h0200, 16'h0008, '0, '0, 1000, 0);
    chk("timeout_reads", n_reads, 4);
    chk("timeout_done_cycle", done_cyc, 46);
    chk("timeout_err", done_err, 1);
    @(negedge clk);
    chk("timeout_back_idle", {bus.req_ready, bus.busy, bus.done}, 3'b100);

    // Zero-length job completes with no AES traffic.
    run_job(16'h4444, 16'h0000, '1, '1, 0, 0);
    chk("zero_done_cycle", done_cyc, 1);
    chk("zero_err", done_err, 0);
    chk("zero_cmd_cycles", n_cmd, 0);

    // Fields change after accept and valid stays high through DONE.
    run_job(16'hbeef, 16'h0003, 128'h000000000000000000000000000000a5,
            128'h0000000000000000000000000000003c, 0, 1);
    chk("hold_c1_data", lg_data[1], 8'hef);
    chk("hold_c2_data", lg_data[2], 8'hbe);
    chk("hold_c3_data", lg_data[3], 8'h03);
    chk("hold_c5_ctr0", {lg_addr[5], lg_data[5]}, {16'hff10, 8'ha5});
    chk("hold_c21_key0", {lg_addr[21], lg_data[21]}, {16'hff20, 8'h3c});
    chk("hold_done_cycle", done_cyc, 40);
    chk("hold_ready_in_done", bus.req_ready, 0);
    @(negedge clk);
    chk("hold_idle_after_done", {bus.req_ready, bus.busy, bus.cmd}, 4'b1000);
    @(negedge clk);
    chk("job2_accepted", {bus.busy, bus.cmd, bus.cmdaddr, bus.cmddata},
        {1'b1, 2'b10, 16'hff02, 8'h5a});
    bus.req_valid = 1'b0;
    begin
      bit seen = 0;
      for (int r = 0; r < 100 && !seen; r++) begin
        @(negedge clk);
        if (bus.done) seen = 1;
      end
      chk("job2_done_seen", seen, 1);
    end

    // Asynchronous reset while writing CTR bytes.
    @(negedge clk);
    bus.req_addr  = 16'h0300;
    bus.req_len   = 16'h0020;
    bus.req_valid = 1'b1;
    resp_busy     = 0;
    rd_base       = rd_count;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrst_in_ctr", {bus.cmd, bus.cmdaddr}, {2'b10, 16'hff13});
    #2 rst = 1'b0;
    #1;
    chk("midrst_cmd", bus.cmd, 0);
    chk("midrst_busy_ready", {bus.busy, bus.req_ready}, 2'b01);
    chk("midrst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int dn = 0;
      int nc = 0;
      repeat (50) begin
        @(negedge clk);
        if (bus.done) dn++;
        if (bus.cmd != 2'b00) nc++;
      end
      chk("midrst_no_done", dn, 0);
      chk("midrst_no_cmd", nc, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_cmd_initiator.md
Name: aes_cmd_initiator

Overview:
- Hardware initiator for the AES accelerator's byte-wide MMIO command port. It plays the same role the 8051 XRAM path does: drives cmd = {write, read}, cmdaddr and cmddata, and samples outdata.
- It takes one encryption descriptor from a host handshake and programs the AES registers: ADDR, LEN, CTR, KEY, then START.
- It then polls the AES state register until idle and reports completion.
- It is used in SoC compositions where a second master, other than the 8051, offloads AES jobs.

Parameters:
- REG_BASE, 16'hff00, base of AES register window: START=+0x00, STATE=+0x01, ADDR=+0x02..+0x03, LEN=+0x04..+0x05, CTR=+0x10..+0x1f, KEY=+0x20..+0x2f.
- POLL_MAX, 16'd1024, maximum number of status reads before a timeout.
- STATUS_IDLE, 8'h00, AES state value meaning idle.
- START_VAL, 8'h01, byte written to START.

Ports:
- clk  in  1  single clock; all flops on posedge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_valid  in  1  host descriptor valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  16  XRAM source/destination address for AES.
- req_len  in  16  byte length.
- req_ctr  in  128  counter block; byte i = bits [8i+7:8i].
- req_key  in  128  key; byte i = bits [8i+7:8i].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only while done=1; 1 = poll timeout.
- cmd  out  2  {write, read} to AES; 2'b10 = write, 2'b01 = read, 2'b00 = none; 2'b11 is never driven.
- cmdaddr  out  16  AES register address.
- cmddata  out  8  write byte.
- outdata  in  8  AES read data, valid the cycle after the read command.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - Outputs: cmd = 00, cmdaddr = 0, cmddata = 0, done = 0, err = 0, busy = 0, req_ready = 1.
  - Byte index and poll counter cleared.
- Reset mid-operation: the job is abandoned immediately and no done pulse is issued. The AES is not reset by this block; the integrator must reset both together.
- All command outputs are registered. cmd is 00 in every state that does not issue a command.
- Accept: on the edge where req_valid & req_ready, latch all request fields. Later changes to req_* are ignored.
- Zero-length job: if req_len == 0, go to DONE. done=1, err=0 the next cycle, and no AES commands are issued.
- States and transitions:
  - IDLE -> WR_ADDR -> WR_LEN -> WR_CTR -> WR_KEY -> WR_START -> POLL_RD <-> POLL_WAIT -> DONE -> IDLE.
  - WR_ADDR: 2 writes, ADDR+0 = addr[7:0], ADDR+1 = addr[15:8].
  - WR_LEN: 2 writes, same little-endian order as WR_ADDR.
  - WR_CTR: 16 writes, CTR+i = ctr byte i, i = 0..15 ascending.
  - WR_KEY: 16 writes, KEY+i = key byte i, ascending.
  - WR_START: 1 write, START = START_VAL.
  - POLL_RD: cmd = 01, cmdaddr = STATE.
  - POLL_WAIT: cmd = 00. On the closing edge, sample outdata:
    - outdata == STATUS_IDLE -> DONE, err = 0;
    - otherwise, if polls issued == POLL_MAX -> DONE, err = 1;
    - else -> POLL_RD.
  - DONE: done = 1 for exactly one cycle, then IDLE. req_ready is 0 during DONE.
- Timing, with the accept edge at cycle 0:
  - Writes occupy cycles 1..37, one byte per cycle, no gaps (37 write cycles total).
  - The first poll read is at cycle 38 and its sample at cycle 39.
  - If the first read returns idle, done is high in cycle 40. Minimum non-zero-length latency is 40 cycles.
- The poll counter is 16-bit, counts read commands issued, and saturates at POLL_MAX. With POLL_MAX = 0, the first non-idle read times out.
- The first status read is never earlier than the cycle after the START write.

Test Plan:
- Reset asserted asynchronously mid-clock while in WR_CTR -> cmd = 00, busy = 0, req_ready = 1 without a clock edge; no done pulse after release.
- Job with addr=16'h1234, len=16'h0010, ctr bytes 0x00..0x0f, key bytes 0x20..0x2f; AES model returns 0 on first poll:
  - write at cycle 1 is (ff02, 34), cycle 2 is (ff03, 12);
  - cycles 3..4 are (ff04, 10), (ff05, 00);
  - CTR writes at cycles 5..20, KEY writes at cycles 21..36, START (ff00, 01) at cycle 37;
  - read ff01 at cycle 38, done=1 and err=0 at cycle 40.
- AES state returns 1 for 3 polls, then 0 -> 4 read commands, each separated by one idle-cmd cycle; done=1, err=0 after the 4th sample.
- POLL_MAX=4, AES state stuck at 1 -> exactly 4 reads, then done=1, err=1; block returns to IDLE.
- req_len=0 -> no cmd ever non-zero; done=1, err=0 at cycle 1.
- Change req_* while busy, and hold req_valid high through DONE -> writes use the latched values; the second job is accepted only on the cycle after DONE.
